ir_burst_tx: RTL and testbench
==============================

IR_BURST_TX -- requirements
Module: ir_burst_tx

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per carrier half-period, legal 1..65535.
REQ-002 Parameter PULSES_LO, default 3: pulses per burst for mode 0, legal 1..6.
REQ-003 Parameter PULSES_HI, default 10: pulses per burst for mode 1, legal 7..31.
REQ-004 Parameter GAP_CYCLES, default 20: low guard cycles after last pulse, legal 1..65535.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  burst request, sampled only in IDLE.
REQ-008 mode  input  1  burst class; 0 = short burst, 1 = long burst.
REQ-009 ir_out  output  1  drive to IR emitter, registered.
REQ-010 busy  output  1  high while a burst or guard gap is in progress, registered.
REQ-011 done  output  1  one-cycle completion strobe, registered.
REQ-012 pulse_cnt  output  5  pulses fully emitted in current/last burst, registered.

Function
REQ-013 Receiver contract: mode 0 bursts SHALL carry fewer than 7 rising edges; mode 1 bursts SHALL carry 7 or more.
REQ-014 FSM states SHALL be IDLE, MARK, SPACE, GAP.
REQ-015 IDLE: start=1 at an edge -> latch mode, clear pulse_cnt, load half-period counter, go to MARK.
REQ-016 Target count N SHALL be PULSES_HI if latched mode=1, else PULSES_LO; mode changes after acceptance have no effect.
REQ-017 MARK: ir_out=1 for exactly HALF_PERIOD cycles, then go to SPACE.
REQ-018 SPACE: ir_out=0 for exactly HALF_PERIOD cycles; at exit increment pulse_cnt; if new count = N go to GAP, else MARK.
REQ-019 GAP: ir_out=0 for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-020 busy SHALL be 1 in MARK, SPACE, GAP and 0 in IDLE; the first busy cycle is the cycle after start is accepted.
REQ-021 Burst length SHALL be N*2*HALF_PERIOD + GAP_CYCLES cycles of busy=1.
REQ-022 done SHALL be 1 for exactly the first IDLE cycle following GAP and 0 otherwise.
REQ-023 start=1 during the done cycle SHALL be accepted (back-to-back bursts, zero idle gap).
REQ-024 start while busy=1 SHALL be ignored, not queued.
REQ-025 pulse_cnt SHALL hold its final value (N) in IDLE until the next accepted start.
REQ-026 Half-period and gap counters SHALL be 16-bit down-counters; no wrap-around within legal parameters.
REQ-027 ir_out SHALL never glitch: it changes only on MARK/SPACE boundaries.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, ir_out=0, busy=0, done=0, pulse_cnt=0, all counters 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately, with no done strobe.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Verification (HALF_PERIOD=4, PULSES_LO=3, PULSES_HI=10, GAP_CYCLES=20)
REQ-031 Mode 0: start=1, mode=0 for one cycle -> 3 high pulses of 4 cycles, 4 low between; busy high 44 cycles; done one cycle; pulse_cnt=3.
REQ-032 Mode 1: start, mode=1 -> 10 pulses; busy high 100 cycles; done one cycle; pulse_cnt=10.
REQ-033 Ignored start: start pulsed at busy cycle 10 of a mode-0 burst -> burst still 44 cycles; no second burst.
REQ-034 Mode change: mode toggled 0->1 at busy cycle 5 of a mode-0 burst -> still exactly 3 pulses.
REQ-035 Back-to-back: start held high continuously with mode=1 -> busy is 100 cycles, then 1 done/IDLE cycle, then busy again; repeats indefinitely.
REQ-036 Reset mid-burst: rst_n=0 at busy cycle 30 of a mode-1 burst -> ir_out, busy, pulse_cnt drop to 0 without waiting for clk; no done strobe.

Source files
------------

// File: rtl/ir_burst_tx_if.sv
// rtl/ir_burst_tx_if.sv - burst request and IR output bundle for ir_burst_tx
interface ir_burst_tx_if;
    logic       start;
    logic       mode;
    logic       ir_out;
    logic       busy;
    logic       done;
    logic [4:0] pulse_cnt;

    modport master (
        output start,
        output mode,
        input  ir_out,
        input  busy,
        input  done,
        input  pulse_cnt
    );

    modport slave (
        input  start,
        input  mode,
        output ir_out,
        output busy,
        output done,
        output pulse_cnt
    );
endinterface

// File: rtl/ir_burst_tx.sv
// rtl/ir_burst_tx.sv - IR carrier burst generator: N carrier pulses then a low guard gap
module ir_burst_tx #(
    parameter int HALF_PERIOD = 4,
    parameter int PULSES_LO   = 3,
    parameter int PULSES_HI   = 10,
    parameter int GAP_CYCLES  = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    ir_burst_tx_if.slave  bus
);
    localparam logic [15:0] HP_LOAD  = 16'(HALF_PERIOD);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);
    localparam logic [4:0]  N_LO     = 5'(PULSES_LO);
    localparam logic [4:0]  N_HI     = 5'(PULSES_HI);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state_q;
    logic        mode_q;
    logic [15:0] hp_cnt_q;
    logic [15:0] gap_cnt_q;
    logic [4:0]  pulse_cnt_q;
    logic        ir_out_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  target_d;
    logic [4:0]  pulse_inc_d;

    // Target follows the mode latched at acceptance, never the live input.
    assign target_d    = mode_q ? N_HI : N_LO;
    assign pulse_inc_d = pulse_cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            hp_cnt_q    <= 16'd0;
            gap_cnt_q   <= 16'd0;
            pulse_cnt_q <= 5'd0;
            ir_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q     <= MARK;
                        mode_q      <= bus.mode;
                        pulse_cnt_q <= 5'd0;
                        hp_cnt_q    <= HP_LOAD;
                        ir_out_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                MARK: begin
                    if (hp_cnt_q == 16'd1) begin
                        state_q  <= SPACE;
                        hp_cnt_q <= HP_LOAD;
                        ir_out_q <= 1'b0;
                    end else begin
                        hp_cnt_q <= hp_cnt_q - 16'd1;
                    end
                end
                SPACE: begin
                    if (hp_cnt_q == 16'd1) begin
                        pulse_cnt_q <= pulse_inc_d;
                        if (pulse_inc_d == target_d) begin
                            state_q   <= GAP;
                            hp_cnt_q  <= 16'd0;
                            gap_cnt_q <= GAP_LOAD;
                        end else begin
                            state_q  <= MARK;
                            hp_cnt_q <= HP_LOAD;
                            ir_out_q <= 1'b1;
                        end
                    end else begin
                        hp_cnt_q <= hp_cnt_q - 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 16'd1) begin
                        state_q   <= IDLE;
                        gap_cnt_q <= 16'd0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ir_out_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_out    = ir_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_ir_burst_tx.sv
// tb/tb_ir_burst_tx.sv - directed and randomized bench for ir_burst_tx
module tb_ir_burst_tx;
    localparam int H    = 4;
    localparam int N_LO = 3;
    localparam int N_HI = 10;
    localparam int G    = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ir_burst_tx_if bus ();

    ir_burst_tx #(
        .HALF_PERIOD (H),
        .PULSES_LO   (N_LO),
        .PULSES_HI   (N_HI),
        .GAP_CYCLES  (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected waveform of a burst, indexed by busy cycle k.
    function automatic logic exp_ir(int k, int n);
        return (k < n * 2 * H) && ((k % (2 * H)) < H);
    endfunction

    function automatic int exp_pc(int k, int n);
        return (k >= n * 2 * H) ? n : k / (2 * H);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a burst at the current negedge and checks it through its done cycle.
    // spk: busy cycle after which start is pulsed; mtk: busy cycle from which mode is flipped.
    task automatic burst(input logic m, input int spk, input int mtk,
                         input logic rnd, input logic hold);
        int n;
        int len;
        n   = m ? N_HI : N_LO;
        len = n * 2 * H + G;
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk("busy", int'(bus.busy), 1);
            chk("ir_out", int'(bus.ir_out), int'(exp_ir(k, n)));
            chk("pulse_cnt", int'(bus.pulse_cnt), exp_pc(k, n));
            chk("done_busy", int'(bus.done), 0);
            if (hold)
                bus.start = 1'b1;
            else if (rnd && k < len - 1)
                bus.start = 1'($urandom);
            else
                bus.start = (k == spk);
            if (rnd)
                bus.mode = 1'($urandom);
            else if (mtk >= 0 && k >= mtk)
                bus.mode = ~m;
        end
        @(negedge clk);
        chk("done_strobe", int'(bus.done), 1);
        chk("busy_done", int'(bus.busy), 0);
        chk("ir_done", int'(bus.ir_out), 0);
        chk("pulse_final", int'(bus.pulse_cnt), n);
    endtask

    task automatic idle_wait(input int cycles, input int n);
        bus.start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_done", int'(bus.done), 0);
            chk("idle_ir", int'(bus.ir_out), 0);
            chk("idle_hold_cnt", int'(bus.pulse_cnt), n);
        end
    endtask

    initial begin
        logic m;
        int   g;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ir", int'(bus.ir_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_cnt", int'(bus.pulse_cnt), 0);

        // First start after reset release is taken on the very next edge.
        rst_n = 1'b1;
        burst(1'b0, -1, -1, 1'b0, 1'b0);
        idle_wait(3, N_LO);
        burst(1'b1, -1, -1, 1'b0, 1'b0);
        idle_wait(2, N_HI);

        // Start pulsed mid-burst must be dropped, not queued.
        burst(1'b0, 9, -1, 1'b0, 1'b0);
        idle_wait(4, N_LO);

        // Mode flip after acceptance must not lengthen the burst.
        burst(1'b0, -1, 4, 1'b0, 1'b0);
        idle_wait(2, N_LO);

        for (int b = 0; b < 8; b++) begin
            m = 1'($urandom);
            g = int'($urandom_range(0, 3));
            burst(m, -1, -1, 1'b1, 1'b0);
            idle_wait(g, m ? N_HI : N_LO);
        end

        // Start held high: bursts separated by exactly one done cycle.
        for (int b = 0; b < 3; b++)
            burst(1'b1, -1, -1, 1'b0, 1'b1);
        idle_wait(2, N_HI);

        // Asynchronous abort at busy cycle 30 of a long burst.
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", int'(bus.busy), 1);
        chk("pre_rst_cnt", int'(bus.pulse_cnt), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ir", int'(bus.ir_out), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_cnt", int'(bus.pulse_cnt), 0);
        chk("async_done", int'(bus.done), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", int'(bus.done), 0);
        end
        rst_n = 1'b1;
        burst(1'b1, -1, -1, 1'b0, 1'b0);
        idle_wait(2, N_HI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
